wb_irq_sched: RTL and testbench
===============================

Name: wb_irq_sched

Overview:
Machine-mode interrupt scheduler for the in-order RV pipeline. It owns the 64-bit mtime/mtimecmp timer and the msip register, synchronises the external interrupt line, and prioritises pending-and-enabled sources. It then chooses the instruction boundary at the writeback stage where the trap is taken: the instruction in WB is killed, and a cause/EPC pair is handed to the CSR/trap unit. It sits beside the WB stage and feeds the same redirect/flush path as system instructions.

Parameters:
XLEN, 32, data width of config bus and cause
PC_WIDTH, 32, program counter width
TICK_DIV, 1, clk cycles per mtime increment (>=1)
MIE_WAIT_MAX, 15, cycles to wait for trap unit to clear MIE before forcing IDLE

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cfg_we  in  1  config write strobe
cfg_addr  in  3  word index: 0 mtime_lo, 1 mtime_hi, 2 mtimecmp_lo, 3 mtimecmp_hi, 4 msip
cfg_wdata  in  XLEN  write data
cfg_rdata  out  XLEN  read data, combinational from cfg_addr; 0 for index 5-7
ext_irq  in  1  asynchronous external interrupt level
mstatus_mie  in  1  global machine interrupt enable
mie_meie / mie_msie / mie_mtie  in  1 each  per-source enables
wb_valid  in  1  WB holds a valid instruction this cycle
wb_pc  in  PC_WIDTH  PC of WB instruction
wb_inst_csr  in  1  WB instruction is a CSR/system access
system_flush  in  1  trap unit redirect in progress this cycle
irq_take  out  1  one-cycle pulse: take interrupt now, kill WB instruction
irq_cause  out  XLEN  mcause value, valid with irq_take
irq_epc  out  PC_WIDTH  mepc value (= wb_pc), valid with irq_take
mip_out  out  3  {meip, mtip, msip} for mip CSR reads

Behaviour:
- Reset: mtime=0, mtimecmp=all-ones, msip=0, sync flops=0, prescaler=0, state IDLE, irq_take=0, mip_out=0.
- ext_irq passes a 2-flop synchroniser; meip = second flop.
- Prescaler counts 0..TICK_DIV-1; mtime increments on wrap; 64-bit wrap to 0 allowed.
- A cfg write to a mtime half replaces that half in the same cycle and suppresses the increment for that cycle. The other half is unchanged, with no carry.
- mtimecmp writes are per half. msip = cfg_wdata[0]; upper bits read 0.
- mtip registered: mtip <= (mtime >= mtimecmp), unsigned 64-bit compare on the post-update values; 1-cycle latency.
- pend = mstatus_mie & ({meip,mtip,msip} & {meie,mtie,msie}) != 0.
- Priority: MEI (code 11) > MSI (3) > MTI (7). irq_cause = {1'b1, zero-ext code}.
- FSM:
  - IDLE: pend -> ARMED.
  - ARMED:
    - If !pend (source or enable dropped), go to IDLE with no take.
    - Else if wb_valid & !wb_inst_csr & !system_flush, drive irq_take=1 combinationally this cycle, with irq_epc=wb_pc and cause from the current winning source; go to WAIT_MIE.
    - Otherwise stay in ARMED. CSR/system instructions in WB are never interrupted; they commit first.
  - WAIT_MIE: irq_take=0. Go to IDLE when mstatus_mie==0, or when a counter reaches MIE_WAIT_MAX. The counter resets on state entry.
- irq_take is never asserted in the same cycle as system_flush. irq_take is never asserted twice without passing through IDLE.
- Reset mid-ARMED/WAIT_MIE returns to IDLE next edge; no pulse is emitted.
- A cfg write and a take in the same cycle are both honoured. The take uses the pre-write pend.

Decomposition:
- Shared package/defines: cfg word indices, cause codes (MEI=11, MSI=3, MTI=7), FSM state encodings, interrupt MSB position.
- One natural sub-module: wb_irq_timer (prescaler, mtime/mtimecmp, cfg write decode, mtip compare). The FSM, priority and sync stay in the top.

Test Plan:
- Reset -> mtime reads 0, mtimecmp_lo/hi read 0xFFFFFFFF, irq_take 0 for 100 cycles with all enables set.
- TICK_DIV=1; write mtimecmp={0,20}; MIE=MTIE=1; stream wb_valid with wb_pc=0x80000100 -> irq_take when mtime>=20 plus 1 cycle, cause 0x80000007, epc 0x80000100; single pulse, then WAIT_MIE until MIE=0.
- Simultaneous ext_irq and msip=1 with all enables -> cause 0x8000000B first. After MIE toggles 0->1 and ext_irq drops, the next take has cause 0x80000003.
- ARMED with wb_inst_csr=1 for 3 cycles, then a normal instruction -> no take during the CSR cycles; take on the 4th, with epc = that instruction's PC.
- ARMED, then clear mie_mtie before any WB-valid cycle -> return to IDLE, no irq_take.
- Write mtime_lo=0xFFFFFFFF, then let it tick -> mtime_hi increments by 1 and mtime_lo reads 0. Write mtime_hi in a tick cycle -> written value held with no increment that cycle.

Source files
------------

// File: rtl/wb_irq_sched_pkg.sv
// Shared constants for the machine-mode interrupt scheduler: config word map,
// mcause codes and FSM state encoding.
package wb_irq_sched_pkg;

   localparam logic [2:0] CFG_MTIME_LO    = 3'd0;
   localparam logic [2:0] CFG_MTIME_HI    = 3'd1;
   localparam logic [2:0] CFG_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] CFG_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] CFG_MSIP        = 3'd4;

   localparam int IRQ_CODE_W = 4;
   localparam logic [IRQ_CODE_W-1:0] CAUSE_MEI = 4'd11;
   localparam logic [IRQ_CODE_W-1:0] CAUSE_MSI = 4'd3;
   localparam logic [IRQ_CODE_W-1:0] CAUSE_MTI = 4'd7;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_ARMED    = 2'd1,
      ST_WAIT_MIE = 2'd2
   } irq_state_e;

endpackage

// File: rtl/wb_irq_timer.sv
// mtime/mtimecmp/msip register block with prescaler and registered mtip compare.
module wb_irq_timer
   import wb_irq_sched_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int TICK_DIV = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cfg_we,
   input  logic [2:0]      cfg_addr,
   input  logic [XLEN-1:0] cfg_wdata,
   output logic [63:0]     mtime,
   output logic [63:0]     mtimecmp,
   output logic            mtip,
   output logic            msip
);

   localparam int PW = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

   logic [PW-1:0] presc;
   logic          tick;
   logic [63:0]   mtime_nxt;
   logic [63:0]   mtimecmp_nxt;

   // A write to either mtime half wins over the tick for that cycle, no carry.
   always_comb begin
      tick         = (presc == PW'(TICK_DIV - 1));
      mtime_nxt    = mtime;
      mtimecmp_nxt = mtimecmp;
      if (cfg_we && cfg_addr == CFG_MTIME_LO)
         mtime_nxt = {mtime[63:32], cfg_wdata[31:0]};
      else if (cfg_we && cfg_addr == CFG_MTIME_HI)
         mtime_nxt = {cfg_wdata[31:0], mtime[31:0]};
      else if (tick)
         mtime_nxt = mtime + 64'd1;
      if (cfg_we && cfg_addr == CFG_MTIMECMP_LO)
         mtimecmp_nxt = {mtimecmp[63:32], cfg_wdata[31:0]};
      else if (cfg_we && cfg_addr == CFG_MTIMECMP_HI)
         mtimecmp_nxt = {cfg_wdata[31:0], mtimecmp[31:0]};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc    <= '0;
         mtime    <= '0;
         mtimecmp <= '1;
         mtip     <= 1'b0;
         msip     <= 1'b0;
      end else begin
         presc    <= tick ? '0 : presc + PW'(1);
         mtime    <= mtime_nxt;
         mtimecmp <= mtimecmp_nxt;
         mtip     <= (mtime_nxt >= mtimecmp_nxt);
         if (cfg_we && cfg_addr == CFG_MSIP)
            msip <= cfg_wdata[0];
      end
   end

endmodule

// File: rtl/wb_irq_sched.sv
// Machine interrupt scheduler: syncs ext_irq, prioritises pending sources and
// takes the trap at a safe writeback boundary.
module wb_irq_sched
   import wb_irq_sched_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int PC_WIDTH     = 32,
   parameter int TICK_DIV     = 1,
   parameter int MIE_WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_we,
   input  logic [2:0]          cfg_addr,
   input  logic [XLEN-1:0]     cfg_wdata,
   output logic [XLEN-1:0]     cfg_rdata,
   input  logic                ext_irq,
   input  logic                mstatus_mie,
   input  logic                mie_meie,
   input  logic                mie_msie,
   input  logic                mie_mtie,
   input  logic                wb_valid,
   input  logic [PC_WIDTH-1:0] wb_pc,
   input  logic                wb_inst_csr,
   input  logic                system_flush,
   output logic                irq_take,
   output logic [XLEN-1:0]     irq_cause,
   output logic [PC_WIDTH-1:0] irq_epc,
   output logic [2:0]          mip_out
);

   localparam int WCW = (MIE_WAIT_MAX < 2) ? 1 : $clog2(MIE_WAIT_MAX + 1);

   logic [63:0]           mtime;
   logic [63:0]           mtimecmp;
   logic                  mtip;
   logic                  msip;
   logic [1:0]            ext_sync;
   logic [2:0]            mip;
   logic [2:0]            active;
   logic                  pend;
   logic [IRQ_CODE_W-1:0] code;
   irq_state_e            state;
   irq_state_e            next_state;
   logic [WCW-1:0]        wait_cnt;

   wb_irq_timer #(.XLEN(XLEN), .TICK_DIV(TICK_DIV)) u_timer (
      .clk       (clk),
      .rst       (rst),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_wdata (cfg_wdata),
      .mtime     (mtime),
      .mtimecmp  (mtimecmp),
      .mtip      (mtip),
      .msip      (msip)
   );

   always_ff @(posedge clk) begin
      if (rst) ext_sync <= 2'b00;
      else     ext_sync <= {ext_sync[0], ext_irq};
   end

   assign mip       = {ext_sync[1], mtip, msip};
   assign active    = mip & {mie_meie, mie_mtie, mie_msie};
   assign pend      = mstatus_mie & (|active);
   assign mip_out   = mip;
   assign irq_epc   = wb_pc;
   assign irq_cause = {1'b1, (XLEN-1)'(code)};

   // External beats software beats timer.
   always_comb begin
      code = CAUSE_MTI;
      if (active[2])      code = CAUSE_MEI;
      else if (active[0]) code = CAUSE_MSI;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         wait_cnt <= '0;
      end else begin
         state    <= next_state;
         wait_cnt <= (state == ST_WAIT_MIE) ? wait_cnt + WCW'(1) : '0;
      end
   end

   // CSR/system instructions and flush cycles are never interrupted.
   always_comb begin
      next_state = state;
      irq_take   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (pend) next_state = ST_ARMED;
         end
         ST_ARMED: begin
            if (!pend) begin
               next_state = ST_IDLE;
            end else if (wb_valid && !wb_inst_csr && !system_flush) begin
               irq_take   = !rst;
               next_state = ST_WAIT_MIE;
            end
         end
         ST_WAIT_MIE: begin
            if (!mstatus_mie || wait_cnt == WCW'(MIE_WAIT_MAX))
               next_state = ST_IDLE;
         end
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         CFG_MTIME_LO:    cfg_rdata = XLEN'(mtime[31:0]);
         CFG_MTIME_HI:    cfg_rdata = XLEN'(mtime[63:32]);
         CFG_MTIMECMP_LO: cfg_rdata = XLEN'(mtimecmp[31:0]);
         CFG_MTIMECMP_HI: cfg_rdata = XLEN'(mtimecmp[63:32]);
         CFG_MSIP:        cfg_rdata = XLEN'(msip);
         default:         cfg_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_wb_irq_sched.sv
// Self-checking bench for wb_irq_sched: directed sequences, a config table and
// randomized traffic compared against a cycle-level behavioural model.
module tb_wb_irq_sched;

   localparam int XLEN     = 32;
   localparam int PCW      = 32;
   localparam int TICK_DIV = 1;
   localparam int WAIT_MAX = 15;

   localparam int P_IDLE  = 0;
   localparam int P_ARMED = 1;
   localparam int P_WAIT  = 2;

   logic            clk;
   logic            rst;
   logic            cfg_we;
   logic [2:0]      cfg_addr;
   logic [XLEN-1:0] cfg_wdata;
   logic [XLEN-1:0] cfg_rdata;
   logic            ext_irq;
   logic            mstatus_mie;
   logic            mie_meie;
   logic            mie_msie;
   logic            mie_mtie;
   logic            wb_valid;
   logic [PCW-1:0]  wb_pc;
   logic            wb_inst_csr;
   logic            system_flush;
   logic            irq_take;
   logic [XLEN-1:0] irq_cause;
   logic [PCW-1:0]  irq_epc;
   logic [2:0]      mip_out;

   wb_irq_sched #(
      .XLEN(XLEN), .PC_WIDTH(PCW), .TICK_DIV(TICK_DIV), .MIE_WAIT_MAX(WAIT_MAX)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_we       (cfg_we),
      .cfg_addr     (cfg_addr),
      .cfg_wdata    (cfg_wdata),
      .cfg_rdata    (cfg_rdata),
      .ext_irq      (ext_irq),
      .mstatus_mie  (mstatus_mie),
      .mie_meie     (mie_meie),
      .mie_msie     (mie_msie),
      .mie_mtie     (mie_mtie),
      .wb_valid     (wb_valid),
      .wb_pc        (wb_pc),
      .wb_inst_csr  (wb_inst_csr),
      .system_flush (system_flush),
      .irq_take     (irq_take),
      .irq_cause    (irq_cause),
      .irq_epc      (irq_epc),
      .mip_out      (mip_out)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: plain 64-bit counters and a phase number.
   logic [63:0] m_time;
   logic [63:0] m_cmp;
   logic        m_msip;
   logic        m_mtip;
   logic        m_s1;
   logic        m_s2;
   int          m_presc;
   int          m_phase;
   int          m_waited;
   bit          m_valid = 0;

   logic            last_take;
   logic [XLEN-1:0] last_cause;
   logic [PCW-1:0]  last_epc;
   logic [XLEN-1:0] last_rdata;
   logic [2:0]      last_mip;

   typedef struct {
      logic [2:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp;
   } cfg_vec_t;

   cfg_vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic bit modelPend();
      logic [2:0] mip;
      mip = {m_s2, m_mtip, m_msip};
      return mstatus_mie && ((mip & {mie_meie, mie_mtie, mie_msie}) != 3'b000);
   endfunction

   function automatic logic [31:0] modelCause();
      if (m_s2 && mie_meie)   return 32'h8000_000B;
      if (m_msip && mie_msie) return 32'h8000_0003;
      return 32'h8000_0007;
   endfunction

   function automatic bit modelTake();
      return !rst && m_phase == P_ARMED && modelPend() && wb_valid && !wb_inst_csr && !system_flush;
   endfunction

   function automatic logic [31:0] modelRead();
      case (cfg_addr)
         3'd0:    return m_time[31:0];
         3'd1:    return m_time[63:32];
         3'd2:    return m_cmp[31:0];
         3'd3:    return m_cmp[63:32];
         3'd4:    return {31'd0, m_msip};
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput();
      bit t;
      last_take  = irq_take;
      last_cause = irq_cause;
      last_epc   = irq_epc;
      last_rdata = cfg_rdata;
      last_mip   = mip_out;
      if (m_valid) begin
         t = modelTake();
         check("take", irq_take, t);
         check("mip", mip_out, {m_s2, m_mtip, m_msip});
         check("rdata", cfg_rdata, modelRead());
         if (t) begin
            check("cause", irq_cause, modelCause());
            check("epc", irq_epc, wb_pc);
         end
      end
   endtask

   task automatic modelStep();
      bit p;
      bit t;
      bit wrap;
      if (rst) begin
         m_time = 64'd0; m_cmp = '1; m_msip = 0; m_mtip = 0;
         m_s1 = 0; m_s2 = 0; m_presc = 0; m_phase = P_IDLE; m_waited = 0;
         m_valid = 1;
         return;
      end
      p = modelPend();
      t = modelTake();
      case (m_phase)
         P_IDLE:  if (p) m_phase = P_ARMED;
         P_ARMED: begin
            if (!p) m_phase = P_IDLE;
            else if (t) begin m_phase = P_WAIT; m_waited = 0; end
         end
         default: begin
            if (!mstatus_mie || m_waited == WAIT_MAX) m_phase = P_IDLE;
            else m_waited++;
         end
      endcase
      wrap    = (m_presc == TICK_DIV - 1);
      m_presc = wrap ? 0 : m_presc + 1;
      if (cfg_we && cfg_addr == 3'd0)      m_time[31:0]  = cfg_wdata;
      else if (cfg_we && cfg_addr == 3'd1) m_time[63:32] = cfg_wdata;
      else if (wrap)                       m_time = m_time + 64'd1;
      if (cfg_we && cfg_addr == 3'd2) m_cmp[31:0]  = cfg_wdata;
      if (cfg_we && cfg_addr == 3'd3) m_cmp[63:32] = cfg_wdata;
      if (cfg_we && cfg_addr == 3'd4) m_msip = cfg_wdata[0];
      m_mtip = (m_time >= m_cmp);
      m_s2   = m_s1;
      m_s1   = ext_irq;
   endtask

   // Inputs are set just after a rising edge; outputs sampled mid-cycle.
   task automatic applyStimulus();
      #4;
      checkOutput();
      @(posedge clk);
      modelStep();
      #1;
   endtask

   task automatic cfgWrite(input logic [2:0] a, input logic [31:0] d);
      cfg_we = 1; cfg_addr = a; cfg_wdata = d;
      applyStimulus();
      cfg_we = 0;
   endtask

   task automatic waitTake(input int bound, output bit got);
      got = 0;
      for (int i = 0; i < bound && !got; i++) begin
         applyStimulus();
         got = last_take;
      end
   endtask

   task automatic setEnables(input logic mie, input logic me, input logic ms, input logic mt);
      mstatus_mie = mie; mie_meie = me; mie_msie = ms; mie_mtie = mt;
   endtask

   initial begin
      bit got;
      int takes;
      rst = 1; cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; ext_irq = 0;
      setEnables(0, 0, 0, 0);
      wb_valid = 0; wb_pc = 0; wb_inst_csr = 0; system_flush = 0;
      @(posedge clk); #1;
      repeat (3) applyStimulus();
      rst = 0;

      // Reset values and quiet period with everything enabled.
      cfg_addr = 3'd0; applyStimulus(); check("rst_mtime_lo", last_rdata, 32'd0);
      check("rst_mip", last_mip, 3'b000);
      cfg_addr = 3'd2; applyStimulus(); check("rst_cmp_lo", last_rdata, 32'hFFFF_FFFF);
      cfg_addr = 3'd3; applyStimulus(); check("rst_cmp_hi", last_rdata, 32'hFFFF_FFFF);
      setEnables(1, 1, 1, 1); wb_valid = 1; wb_pc = 32'h8000_0000;
      takes = 0;
      for (int i = 0; i < 100; i++) begin applyStimulus(); takes += int'(last_take); end
      check("rst_no_take", takes, 0);

      // Timer interrupt at mtime 20, taken one cycle later.
      setEnables(0, 0, 0, 0); wb_valid = 0;
      cfgWrite(3'd1, 0); cfgWrite(3'd0, 0); cfgWrite(3'd3, 0); cfgWrite(3'd2, 20);
      setEnables(1, 0, 0, 1); wb_valid = 1; wb_pc = 32'h8000_0100; cfg_addr = 3'd0;
      waitTake(60, got);
      check("mti_taken", got, 1);
      check("mti_mtime", last_rdata, 21);
      check("mti_cause", last_cause, 32'h8000_0007);
      check("mti_epc", last_epc, 32'h8000_0100);
      takes = 0;
      for (int i = 0; i < 5; i++) begin applyStimulus(); takes += int'(last_take); end
      check("mti_single_pulse", takes, 0);
      mstatus_mie = 0; applyStimulus(); applyStimulus();

      // External and software pending together: external first, then software.
      cfgWrite(3'd4, 1); ext_irq = 1;
      repeat (3) applyStimulus();
      setEnables(1, 1, 1, 1); wb_pc = 32'h8000_0200;
      waitTake(10, got);
      check("mei_taken", got, 1);
      check("mei_cause", last_cause, 32'h8000_000B);
      mstatus_mie = 0; ext_irq = 0;
      repeat (4) applyStimulus();
      mstatus_mie = 1;
      waitTake(10, got);
      check("msi_taken", got, 1);
      check("msi_cause", last_cause, 32'h8000_0003);
      check("msi_epc", last_epc, 32'h8000_0200);

      // CSR instructions in WB commit before the trap.
      setEnables(0, 0, 0, 1); cfgWrite(3'd4, 0); applyStimulus();
      wb_valid = 0; mstatus_mie = 1;
      applyStimulus(); applyStimulus();
      wb_valid = 1; wb_inst_csr = 1; takes = 0;
      for (int i = 0; i < 3; i++) begin
         wb_pc = 32'h8000_0300 + 32'(i * 4);
         applyStimulus(); takes += int'(last_take);
      end
      check("csr_no_take", takes, 0);
      wb_inst_csr = 0; wb_pc = 32'h8000_030C; applyStimulus();
      check("csr_then_take", last_take, 1);
      check("csr_then_epc", last_epc, 32'h8000_030C);
      mstatus_mie = 0; applyStimulus(); applyStimulus();

      // Source enable dropped while armed.
      wb_valid = 0; mstatus_mie = 1; applyStimulus(); applyStimulus();
      mie_mtie = 0; wb_valid = 1; takes = 0;
      for (int i = 0; i < 5; i++) begin applyStimulus(); takes += int'(last_take); end
      check("disarm_no_take", takes, 0);
      setEnables(0, 0, 0, 0);

      // mtime low-half wrap and write-over-tick.
      cfgWrite(3'd1, 5); cfgWrite(3'd0, 32'hFFFF_FFFF);
      cfg_addr = 3'd0; applyStimulus(); check("wrap_lo_before", last_rdata, 32'hFFFF_FFFF);
      cfg_addr = 3'd1; applyStimulus(); check("wrap_hi_after", last_rdata, 6);
      cfg_addr = 3'd0; applyStimulus(); check("wrap_lo_after", last_rdata, 1);
      cfgWrite(3'd1, 32'h77);
      cfg_addr = 3'd1; applyStimulus(); check("hi_write_held", last_rdata, 32'h77);
      cfgWrite(3'd0, 32'h100);
      cfg_addr = 3'd0; applyStimulus(); check("lo_write_no_inc", last_rdata, 32'h100);

      // Reset while armed: no pulse, back to reset values.
      setEnables(1, 0, 0, 1); wb_valid = 0; applyStimulus(); applyStimulus();
      rst = 1; wb_valid = 1; applyStimulus();
      check("rst_armed_no_take", last_take, 0);
      applyStimulus(); rst = 0;
      applyStimulus();
      check("post_rst_take", last_take, 0);
      check("post_rst_mip", last_mip, 3'b000);
      setEnables(0, 0, 0, 0);

      // Config register table.
      vecs[0] = '{3'd2, 32'h1234_5678, 32'h1234_5678};
      vecs[1] = '{3'd3, 32'hCAFE_BABE, 32'hCAFE_BABE};
      vecs[2] = '{3'd4, 32'hFFFF_FFFF, 32'h0000_0001};
      vecs[3] = '{3'd4, 32'h0000_0002, 32'h0000_0000};
      vecs[4] = '{3'd5, 32'hDEAD_BEEF, 32'h0000_0000};
      vecs[5] = '{3'd7, 32'h1111_1111, 32'h0000_0000};
      vecs[6] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      vecs[7] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      for (int i = 0; i < 8; i++) begin
         cfgWrite(vecs[i].addr, vecs[i].wdata);
         cfg_addr = vecs[i].addr; applyStimulus();
         check($sformatf("vec%0d", i), last_rdata, vecs[i].exp);
      end

      // Randomized traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         rst          = ($urandom_range(0, 399) == 0);
         if ($urandom_range(0, 9) == 0) ext_irq = ~ext_irq;
         if ($urandom_range(0, 19) == 0) mstatus_mie = ~mstatus_mie;
         if ($urandom_range(0, 14) == 0) mie_meie = ~mie_meie;
         if ($urandom_range(0, 14) == 0) mie_msie = ~mie_msie;
         if ($urandom_range(0, 14) == 0) mie_mtie = ~mie_mtie;
         wb_valid     = ($urandom_range(0, 2) != 0);
         wb_inst_csr  = ($urandom_range(0, 4) == 0);
         system_flush = ($urandom_range(0, 5) == 0);
         wb_pc        = $urandom() & 32'hFFFF_FFFC;
         cfg_we       = ($urandom_range(0, 9) == 0);
         cfg_addr     = 3'($urandom_range(0, 7));
         cfg_wdata    = $urandom_range(0, 1) ? 32'($urandom_range(0, 300)) : $urandom();
         applyStimulus();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
